// File: rtl/shift_sched_pkg.sv
// shift_sched_pkg: shared types and defaults for the shared shift/rotate scheduler.
package shift_sched_pkg;

   localparam int W_DEF = 8;

   typedef enum logic [1:0] {
      OP_SHL  = 2'd0,
      OP_SHR  = 2'd1,
      OP_ROTR = 2'd2,
      OP_SRA  = 2'd3
   } shift_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/shift_sched_step.sv
// shift_step: combinational single-bit shift/rotate step.
// Build option SHIFT_SCHED_ARITH_EN: when defined, op 3 fills with the sign bit;
// when undefined, op 3 is a plain logical right shift and no sign-fill path exists.
module shift_step
   import shift_sched_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  shift_op_e      op_i,
   input  logic [W-1:0]   x_i,
   output logic [W-1:0]   y_o
);

   // One bit of movement for the selected op
   always_comb begin
      y_o = x_i;
      unique case (op_i)
         OP_SHL:  y_o = {x_i[W-2:0], 1'b0};
         OP_SHR:  y_o = {1'b0, x_i[W-1:1]};
         OP_ROTR: y_o = {x_i[0], x_i[W-1:1]};
`ifdef SHIFT_SCHED_ARITH_EN
         OP_SRA:  y_o = {x_i[W-1], x_i[W-1:1]};
`else
         OP_SRA:  y_o = {1'b0, x_i[W-1:1]};
`endif
         default: y_o = x_i;
      endcase
   end

endmodule

// File: rtl/shift_sched.sv
// shift_sched: one iterative shift/rotate engine shared round-robin by NREQ requesters.
// Build option SHIFT_SCHED_ARITH_EN selects sign-fill for op 3 (see shift_step).
//
//   state   | meaning
//   ST_IDLE | arbitrate; req_ready one-hot to the winner
//   ST_EXEC | one 1-bit step per cycle until the count runs out
//   ST_RESP | result held on rsp_data_o/rsp_id_o until rsp_ready_i
module shift_sched
   import shift_sched_pkg::*;
#(
   parameter  int NREQ = 4,
   parameter  int W    = W_DEF,
   localparam int AW   = $clog2(W),
   localparam int IW   = $clog2(NREQ)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NREQ-1:0]   req_valid_i,
   output logic [NREQ-1:0]   req_ready_o,
   input  logic [2*NREQ-1:0] req_op_i,
   input  logic [W*NREQ-1:0] req_data_i,
   input  logic [AW*NREQ-1:0] req_amt_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [W-1:0]      rsp_data_o,
   output logic [IW-1:0]     rsp_id_o
);

   state_e          state_q, state_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [W-1:0]    x_q, x_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   id_q, id_d;
   shift_op_e       op_q, op_d;

   logic            grant_vld;
   logic [IW-1:0]   grant_id;
   logic            hi_vld, lo_vld;
   logic [IW-1:0]   hi_id, lo_id;
   shift_op_e       sel_op;
   logic [W-1:0]    sel_data;
   logic [AW-1:0]   sel_amt;
   logic [W-1:0]    step_y;
   logic            accept;

   // Round-robin pick: lowest valid at/after rr_ptr, else lowest valid overall (wrap)
   always_comb begin
      hi_vld = 1'b0;
      lo_vld = 1'b0;
      hi_id  = '0;
      lo_id  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid_i[i] && (IW'(i) >= rr_ptr_q) && !hi_vld) begin
            hi_vld = 1'b1;
            hi_id  = IW'(i);
         end
         if (req_valid_i[i] && !lo_vld) begin
            lo_vld = 1'b1;
            lo_id  = IW'(i);
         end
      end
      grant_vld = hi_vld | lo_vld;
      grant_id  = hi_vld ? hi_id : lo_id;
   end

   // Mux the winner's operands
   always_comb begin
      sel_op   = OP_SHL;
      sel_data = '0;
      sel_amt  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (IW'(i) == grant_id) begin
            sel_op   = shift_op_e'(req_op_i[2*i +: 2]);
            sel_data = req_data_i[W*i +: W];
            sel_amt  = req_amt_i[AW*i +: AW];
         end
      end
   end

   assign accept = (state_q == ST_IDLE) && grant_vld;

   shift_step #(.W(W)) u_step (
      .op_i (op_q),
      .x_i  (x_q),
      .y_o  (step_y)
   );

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state; amt==0 skips EXEC so the result is the operand itself
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (grant_vld) state_d = (sel_amt == '0) ? ST_RESP : ST_EXEC;
         ST_EXEC: if (cnt_q == AW'(1)) state_d = ST_RESP;
         ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs; grant is suppressed while reset is asserted so outputs read zero
   always_comb begin
      req_ready_o = '0;
      if ((state_q == ST_IDLE) && grant_vld && !rst_i) req_ready_o[grant_id] = 1'b1;
      rsp_valid_o = (state_q == ST_RESP);
   end

   // Datapath next values: latch on handshake, step while executing
   always_comb begin
      x_d      = x_q;
      cnt_d    = cnt_q;
      id_d     = id_q;
      op_d     = op_q;
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         x_d      = sel_data;
         cnt_d    = sel_amt;
         id_d     = grant_id;
         op_d     = sel_op;
         rr_ptr_d = (grant_id == IW'(NREQ-1)) ? '0 : grant_id + IW'(1);
      end else if (state_q == ST_EXEC) begin
         x_d   = step_y;
         cnt_d = cnt_q - AW'(1);
      end
   end

   // Datapath registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         x_q      <= '0;
         cnt_q    <= '0;
         id_q     <= '0;
         op_q     <= OP_SHL;
         rr_ptr_q <= '0;
      end else begin
         x_q      <= x_d;
         cnt_q    <= cnt_d;
         id_q     <= id_d;
         op_q     <= op_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign rsp_data_o = x_q;
   assign rsp_id_o   = id_q;

endmodule
